button_ctrl: RTL and testbench
==============================

# button_ctrl

Multi-channel push-button controller for the lab board front end. It synchronizes N raw button inputs and debounces them against one shared sample-tick prescaler. Each channel is sequenced through a press / hold / auto-repeat / release state machine. The block emits single-cycle event pulses (press, release, long-press, repeat) for downstream counters and mode FSMs, so those blocks never see raw or level-held buttons.

## Interface

- `N`, default 4: number of button channels.
- `TICK_DIV`, default 10000: clk cycles per sample tick.
- `STABLE_TICKS`, default 4: consecutive disagreeing samples required to change debounced level.
- `LONG_TICKS`, default 100: ticks held before long-press event.
- `REPEAT_TICKS`, default 25: ticks between repeat events after long-press.
- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high; clears all state.
- `btn_in` in N: raw asynchronous button inputs, 1 = pressed.
- `btn_level` out N: debounced level per channel.
- `press` out N: 1-cycle pulse on debounced 0->1.
- `release` out N: 1-cycle pulse on debounced 1->0.
- `long_press` out N: 1-cycle pulse when held `LONG_TICKS`.
- `repeat` out N: 1-cycle pulse every `REPEAT_TICKS` after long-press while held.

## Operation

- **Synchronizer:** `btn_in` passes through a 2-flop synchronizer per bit, giving `sync`. All decisions use `sync`.
- **Prescaler:** counter runs 0..`TICK_DIV`-1 and wraps. `tick` is high for one cycle when count == `TICK_DIV`-1. Channels act only on tick cycles.
- **Per-channel debounce counter `deb`:**
  - On tick, if `sync` != `btn_level`: `deb`++. Otherwise `deb` = 0.
  - When the increment would reach `STABLE_TICKS`: toggle `btn_level` and clear `deb`.
- **Per-channel FSM states:** RELEASED, HELD, REPEATING.
  - RELEASED: level toggles to 1 -> HELD, `press` pulse, `hold` = 0.
  - HELD: each tick `hold`++. When `hold` reaches `LONG_TICKS` -> REPEATING, `long_press` pulse, `rep` = 0. Level toggles to 0 -> RELEASED, `release` pulse.
  - REPEATING: each tick `rep`++. When `rep` reaches `REPEAT_TICKS` -> `repeat` pulse, `rep` = 0. Level toggles to 0 -> RELEASED, `release` pulse.
- **Simultaneous events:** if release completes on the same tick that `long_press` or `repeat` would fire, release wins and the other pulse is suppressed.
- `hold` and `rep` keep counting during a pending (incomplete) release.
- **Glitch handling:** a glitch shorter than `STABLE_TICKS` ticks resets `deb` and produces no event.
- **Channel independence:** channels are fully independent. Any combination of pulses may be active in the same cycle across channels.
- **Counter widths:** $clog2(max+1) of the respective parameter. Counters saturate by construction and never wrap.

## Timing

- Reset (synchronous, `reset`=1 at posedge): prescaler = 0, all `deb`/`hold`/`rep` = 0, FSMs = RELEASED, synchronizer flops = 0, all outputs 0 the following cycle.
- Reset asserted mid-press: outputs go to 0 with no `release` pulse. After reset, a still-held button must re-debounce and produce a fresh `press`.
- All outputs are registered. Event pulses and the `btn_level` change appear in the cycle after the deciding tick and last exactly 1 cycle.
- Press latency from a clean `btn_in` edge: 2 cycles (sync) plus `STABLE_TICKS` ticks, to the next tick boundary, plus 1 cycle.
- Long-press: `LONG_TICKS` ticks after the `press` tick. Repeats: every `REPEAT_TICKS` ticks thereafter.

## Structure

- **Shared package `button_pkg`:** FSM state enum (RELEASED/HELD/REPEATING) and the counter-width function.
- **Sub-module `button_channel`:** one channel's synchronizer, `deb`/`hold`/`rep` counters and FSM. Inputs `clk`, `reset`, `tick`, raw bit; outputs the 5 per-channel signals.
- **Top `button_ctrl`:** the prescaler plus a generate loop of N `button_channel` instances.

## Test plan

All scenarios use N=2, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=4.

1. **Clean press:** `btn_in[0]`=1 held -> exactly one `press[0]` pulse after the 3rd tick. `btn_level[0]`=1 the same cycle. No other pulses.
2. **Bounce:** `btn_in[0]` toggles every 5 cycles for 60 cycles, then stays 1 -> no pulses during the bounce. A single `press` follows 3 ticks after settling.
3. **Long hold:** hold 30 ticks -> `long_press` 10 ticks after `press`, then `repeat` at +4, +8, +12, +16 ticks. Then release -> one `release`, no further repeats.
4. **Collision:** start release so it completes on the tick where `hold`=10 -> `release` pulses and `long_press` never pulses.
5. **Reset mid-hold:** `reset` while in REPEATING -> all outputs 0 next cycle, no `release`. With `btn_in` still 1, a fresh `press` after 3 ticks.
6. **Independence:** both channels pressed 1 tick apart -> `press[0]` and `press[1]` exactly 1 tick (4 cycles) apart with no cross-talk.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button controller.
//   btn_state_e : per-channel sequencing state
//   cnt_w()     : bit width needed to hold values 0..max_val
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } btn_state_e;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchronizer, tick-driven debounce,
// and press / hold / auto-repeat / release sequencing.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   tick         : shared sample strobe; all channel decisions happen on it
//   btn_raw      : raw asynchronous button bit (1 = pressed)
//   level        : debounced level (registered)
//   press        : 1-cycle pulse on debounced 0->1
//   release_evt  : 1-cycle pulse on debounced 1->0
//   long_press   : 1-cycle pulse after LONG_TICKS ticks held
//   repeat_evt   : 1-cycle pulse every REPEAT_TICKS ticks after long_press
// "release" and "repeat" are reserved words, hence the _evt suffix.
module button_channel
  import button_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_evt,
  output logic long_press,
  output logic repeat_evt
);

  localparam int DW = cnt_w(STABLE_TICKS);
  localparam int HW = cnt_w(LONG_TICKS);
  localparam int RW = cnt_w(REPEAT_TICKS);
  // Compare against "max-1" so the increment that would reach max fires.
  localparam logic [DW-1:0] DEB_LAST  = DW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

  logic          sync1, sync2;
  btn_state_e    state, state_nx;
  logic [DW-1:0] deb, deb_nx;
  logic [HW-1:0] hold, hold_nx;
  logic [RW-1:0] rep, rep_nx;
  logic          level_nx, press_nx, release_nx, long_nx, repeat_nx;
  logic          toggle;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      state       <= RELEASED;
      deb         <= '0;
      hold        <= '0;
      rep         <= '0;
      level       <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      state       <= state_nx;
      deb         <= deb_nx;
      hold        <= hold_nx;
      rep         <= rep_nx;
      level       <= level_nx;
      press       <= press_nx;
      release_evt <= release_nx;
      long_press  <= long_nx;
      repeat_evt  <= repeat_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    deb_nx     = deb;
    hold_nx    = hold;
    rep_nx     = rep;
    level_nx   = level;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    long_nx    = 1'b0;
    repeat_nx  = 1'b0;
    toggle     = 1'b0;
    if (tick) begin
      // Debounce: any agreeing sample restarts the count.
      if (sync2 != level) begin
        if (deb == DEB_LAST) begin
          toggle   = 1'b1;
          deb_nx   = '0;
          level_nx = ~level;
        end else begin
          deb_nx = deb + 1'b1;
        end
      end else begin
        deb_nx = '0;
      end

      // In RELEASED the level is 0, elsewhere 1, so toggle gives direction.
      // A completing release takes priority over long_press / repeat.
      case (state)
        RELEASED: begin
          if (toggle) begin
            state_nx = HELD;
            press_nx = 1'b1;
            hold_nx  = '0;
          end
        end
        HELD: begin
          hold_nx = hold + 1'b1;
          if (toggle) begin
            state_nx   = RELEASED;
            release_nx = 1'b1;
          end else if (hold == HOLD_LAST) begin
            state_nx = REPEATING;
            long_nx  = 1'b1;
            rep_nx   = '0;
          end
        end
        REPEATING: begin
          rep_nx = rep + 1'b1;
          if (toggle) begin
            state_nx   = RELEASED;
            release_nx = 1'b1;
          end else if (rep == REP_LAST) begin
            repeat_nx = 1'b1;
            rep_nx    = '0;
          end
        end
        default: state_nx = RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/button_ctrl.sv
// Multi-channel push-button controller: a shared sample-tick prescaler
// feeding N independent debounce / event channels.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   btn_in[N]    : raw asynchronous buttons (1 = pressed)
//   btn_level[N] : debounced levels
//   press / release_evt / long_press / repeat_evt [N] : 1-cycle event pulses
module button_ctrl
  import button_pkg::*;
#(
  parameter int N            = 4,
  parameter int TICK_DIV     = 10000,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_evt,
  output logic [N-1:0] long_press,
  output logic [N-1:0] repeat_evt
);

  localparam int PW = cnt_w(TICK_DIV - 1);
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset)     pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    button_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .btn_raw    (btn_in[i]),
      .level      (btn_level[i]),
      .press      (press[i]),
      .release_evt(release_evt[i]),
      .long_press (long_press[i]),
      .repeat_evt (repeat_evt[i])
    );
  end

endmodule

// File: tb/tb_button_ctrl.sv
// Scoreboard bench for button_ctrl (N=2, TICK_DIV=4, STABLE=3, LONG=10, REPEAT=4).
// Stimulus pushes {kind, channel, cycle} expectations; a negedge monitor
// matches every observed pulse against them and flags overdue ones.
// Timing rule used throughout: a btn change driven at an aligned negedge
// (cycle b, tick boundary) yields the debounced event at cycle b+12.
module tb_button_ctrl;

  localparam int N = 2;
  localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_REP = 3;

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level, press, release_evt, long_press, repeat_evt;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  button_ctrl #(
    .N(N), .TICK_DIV(4), .STABLE_TICKS(3), .LONG_TICKS(10), .REPEAT_TICKS(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .press      (press),
    .release_evt(release_evt),
    .long_press (long_press),
    .repeat_evt (repeat_evt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_PRESS: return "press";
      K_REL:   return "release";
      K_LONG:  return "long_press";
      default: return "repeat";
    endcase
  endfunction

  task automatic push_exp(input int k, input int c, input int at);
    exp_t e;
    e.kind = k; e.ch = c; e.cyc = at;
    q.push_back(e);
  endtask

  task automatic wait_t(input int n);
    repeat (4 * n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " btn_level"},   btn_level,   '0);
    chk({tag, " press"},       press,       '0);
    chk({tag, " release"},     release_evt, '0);
    chk({tag, " long_press"},  long_press,  '0);
    chk({tag, " repeat"},      repeat_evt,  '0);
  endtask

  // Monitor: every pulse must match a pending expectation at this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < N; c++) begin
        for (int k = 0; k < 4; k++) begin
          logic [N-1:0] vec;
          int idx;
          case (k)
            K_PRESS: vec = press;
            K_REL:   vec = release_evt;
            K_LONG:  vec = long_press;
            default: vec = repeat_evt;
          endcase
          if (vec[c] === 1'b1) begin
            idx = -1;
            foreach (q[i])
              if (idx < 0 && q[i].kind == k && q[i].ch == c && q[i].cyc == cyc) idx = i;
            checks++;
            if (idx >= 0) q.delete(idx);
            else begin
              errors++;
              $display("FAIL unexpected %s[%0d]: got pulse at cyc %0d, required none", kname(k), c, cyc);
            end
            if (k == K_PRESS || k == K_REL) begin
              checks++;
              if (btn_level[c] !== (k == K_PRESS)) begin
                errors++;
                $display("FAIL level with %s[%0d]: got %b, required %b", kname(k), c, btn_level[c], (k == K_PRESS));
              end
            end
          end
        end
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed %s[%0d]: got no pulse, required at cyc %0d", kname(q[i].kind), q[i].ch, q[i].cyc);
          q.delete(i);
        end
      end
    end
  end

  initial begin
    int b;
    reset  = 1'b1;
    btn_in = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset  = 1'b0;
    mon_en = 1'b1;
    wait_t(2);

    // Clean press, then long hold with repeats, then release.
    b = cyc;
    btn_in[0] = 1'b1;
    push_exp(K_PRESS, 0, b + 12);
    push_exp(K_LONG,  0, b + 52);
    for (int r = 1; r <= 4; r++) push_exp(K_REP, 0, b + 52 + 16 * r);
    wait_t(29);
    btn_in[0] = 1'b0;
    push_exp(K_REL, 0, b + 128);
    wait_t(10);

    // Bounce: 5-cycle toggles never give 3 disagreeing ticks in a row.
    b = cyc;
    for (int i = 0; i < 12; i++) begin
      btn_in[0] = (i % 2 == 0);
      repeat (5) @(negedge clk);
    end
    btn_in[0] = 1'b1;
    push_exp(K_PRESS, 0, b + 72);
    wait_t(3);
    btn_in[0] = 1'b0;
    push_exp(K_REL, 0, b + 84);
    wait_t(5);

    // Collision: release completes on the tick long_press would fire.
    b = cyc;
    btn_in[0] = 1'b1;
    push_exp(K_PRESS, 0, b + 12);
    wait_t(10);
    btn_in[0] = 1'b0;
    push_exp(K_REL, 0, b + 52);
    wait_t(10);

    // Reset while REPEATING: no release, then a fresh press.
    b = cyc;
    btn_in[0] = 1'b1;
    push_exp(K_PRESS, 0, b + 12);
    push_exp(K_LONG,  0, b + 52);
    push_exp(K_REP,   0, b + 68);
    wait_t(18);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset mid-hold");
    reset = 1'b0;
    b = cyc;
    push_exp(K_PRESS, 0, b + 12);
    wait_t(3);
    btn_in[0] = 1'b0;
    push_exp(K_REL, 0, b + 24);
    wait_t(6);

    // Independence: presses one tick apart on the two channels.
    b = cyc;
    btn_in[0] = 1'b1;
    push_exp(K_PRESS, 0, b + 12);
    wait_t(1);
    btn_in[1] = 1'b1;
    push_exp(K_PRESS, 1, b + 16);
    wait_t(3);
    btn_in = '0;
    push_exp(K_REL, 0, b + 28);
    push_exp(K_REL, 1, b + 28);
    wait_t(6);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover expectations: got %0d pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
